bus_line_fill: RTL and testbench
================================

// Module: bus_line_fill
// PURPOSE
//  Cache-side bus master: turns one cache-miss request into one bus read
//  transaction and assembles the burst into a full line.
//  One instance per cache (I$, D$); its bus_req* outputs feed the arbiter's
//  per-cache request inputs; bus_resp* inputs come from the shared response bus.
// PARAMETERS
//  BUS_DATA_WIDTH  64  width of bus_req / bus_resp; one beat
//  BUS_TAG_WIDTH   13  width of bus_reqtag / bus_resptag
//  BEATS           8   beats per line; power of 2, >=2; line = BEATS*BUS_DATA_WIDTH bits
//  SRC_ID          0   8-bit requester id placed in reqtag[7:0]
// PORTS
//  clk          in   1                 clock
//  reset        in   1                 synchronous, active-high
//  fill_req     in   1                 cache requests line fill
//  fill_addr    in   BUS_DATA_WIDTH    miss byte address
//  fill_ready   out  1                 block idle, fill_req accepted this cycle
//  fill_done    out  1                 one-cycle pulse, fill_line valid
//  fill_line    out  BEATS*BUS_DATA_WIDTH  assembled line, beat0 in bits [63:0]
//  bus_reqcyc   out  1                 request valid to arbiter
//  bus_req      out  BUS_DATA_WIDTH    line-aligned request address
//  bus_reqtag   out  BUS_TAG_WIDTH     {1'b1 read, 4'b0001 memory, SRC_ID[7:0]}
//  bus_reqack   in   1                 request accepted
//  bus_respcyc  in   1                 response beat valid
//  bus_resp     in   BUS_DATA_WIDTH    response beat data
//  bus_resptag  in   BUS_TAG_WIDTH     response tag
//  bus_respack  out  1                 beat consumed (combinational, same cycle)
// BEHAVIOUR
//  Reset: state IDLE; fill_ready=1; fill_done=0; fill_line=0; bus_reqcyc=0;
//   bus_req=0; bus_reqtag=0; bus_respack=0; beat counter=0.
//  Reset mid-transaction aborts the fill; no fill_done, line cleared.
//  FSM IDLE -> REQ -> RESP -> DONE -> IDLE:
//  IDLE: fill_ready=1. fill_req=1 latches addr with low log2(BEATS*8) bits
//   cleared -> REQ next cycle. bus_respcyc ignored (respack=0).
//  REQ: bus_reqcyc=1, bus_req/bus_reqtag held stable until bus_reqack=1 is
//   sampled; that edge -> RESP. reqcyc drops the cycle after ack.
//  RESP: each cycle bus_respcyc=1 (and tag accepted, see CONFIGURATION):
//   bus_respack=1 same cycle, bus_resp written to beat[cnt], cnt++.
//   Gaps (respcyc=0) allowed, respack=0. Beat BEATS-1 -> DONE.
//  DONE: fill_done=1 one cycle, fill_ready=0 -> IDLE. cnt wraps to 0.
//  fill_line holds value until next fill's first beat overwrites it.
//  Latency, zero-wait bus: req-to-done = 1 (REQ) + BEATS + 1 cycles min.
//  fill_req while not IDLE ignored; requester must hold fill_req until
//   fill_ready. Address latched only at accept; later fill_addr changes ignored.
//  bus_reqack outside REQ ignored. bus_respcyc outside RESP: respack=0.
// CONFIGURATION
//  FILL_TAG_CHECK_EN defined: in RESP a beat is accepted only if
//   bus_resptag == bus_reqtag; mismatched beats get respack=0, not stored,
//   cnt unchanged (beat belongs to the other cache).
//  Undefined: every bus_respcyc in RESP is accepted regardless of tag.
// TESTING
//  1 reset, fill_req=1 addr=0x1234 -> next cycle reqcyc=1, req=0x1200,
//    reqtag=0x1100|SRC_ID; ack at cycle 3 -> reqcyc=0 cycle 4.
//  2 8 back-to-back beats 0x11..0x88 -> respack=1 each, fill_done 1 cycle
//    after beat 8, fill_line[63:0]=0x11, [511:448]=0x88.
//  3 beats with 1-cycle gaps between -> respack only on valid beats; same line.
//  4 fill_req pulsed during RESP -> ignored; second fill starts only after
//    fill_ready returns, with address sampled then.
//  5 reset asserted after beat 3 -> all outputs reset values next cycle,
//    no fill_done; new fill completes normally.
//  6 FILL_TAG_CHECK_EN: beat with resptag=0x1100|(SRC_ID+1) -> respack=0,
//    cnt unchanged; without macro same beat accepted.

Source files
------------

// File: rtl/bus_line_fill.sv
// Cache-side bus master: one miss -> one line-aligned read request, burst beats assembled into a line.
// Optional: define FILL_TAG_CHECK_EN to accept only response beats whose tag matches this instance's request tag.
module bus_line_fill #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int BEATS          = 8,
    parameter int SRC_ID         = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              fill_req,
    input  logic [BUS_DATA_WIDTH-1:0]         fill_addr,
    output logic                              fill_ready,
    output logic                              fill_done,
    output logic [BEATS*BUS_DATA_WIDTH-1:0]   fill_line,
    output logic                              bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0]         bus_req,
    output logic [BUS_TAG_WIDTH-1:0]          bus_reqtag,
    input  logic                              bus_reqack,
    input  logic                              bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0]         bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]          bus_resptag,
    output logic                              bus_respack
);

    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int OFF_W = $clog2(BEATS * (BUS_DATA_WIDTH / 8));
    localparam logic [7:0]                SRC_ID8   = 8'(SRC_ID);
    localparam logic [12:0]               TAG13     = {1'b1, 4'b0001, SRC_ID8};
    localparam logic [BUS_TAG_WIDTH-1:0]  REQ_TAG   = BUS_TAG_WIDTH'(TAG13);
    localparam logic [BUS_DATA_WIDTH-1:0] LINE_MASK =
        ~((BUS_DATA_WIDTH'(1) << OFF_W) - BUS_DATA_WIDTH'(1));
    localparam logic [CNT_W-1:0]          LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                       state_reg, state_next;
    logic [BUS_DATA_WIDTH-1:0]    addr_reg, addr_next;
    logic [BUS_TAG_WIDTH-1:0]     tag_reg, tag_next;
    logic [CNT_W-1:0]             cnt_reg, cnt_next;
    logic                         accept;
    logic                         tag_ok;
    logic                         beat_we;
    logic                         last_beat;

`ifdef FILL_TAG_CHECK_EN
    // Beats carrying another requester's tag belong to the other cache.
    assign tag_ok = (bus_resptag == tag_reg);
`else
    logic unused_resptag;
    assign unused_resptag = ^bus_resptag;
    assign tag_ok         = 1'b1;
`endif

    assign accept    = (state_reg == ST_IDLE) && fill_req;
    assign beat_we   = (state_reg == ST_RESP) && bus_respcyc && tag_ok;
    assign last_beat = (cnt_reg == LAST_BEAT);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (fill_req)              state_next = ST_REQ;
            ST_REQ:  if (bus_reqack)            state_next = ST_RESP;
            ST_RESP: if (beat_we && last_beat)  state_next = ST_DONE;
            ST_DONE:                            state_next = ST_IDLE;
            default:                            state_next = ST_IDLE;
        endcase
    end

    // Output logic; respack is combinational so a beat is consumed in the cycle it appears
    always_comb begin
        fill_ready  = 1'b0;
        fill_done   = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_respack = 1'b0;
        case (state_reg)
            ST_IDLE: fill_ready  = 1'b1;
            ST_REQ:  bus_reqcyc  = 1'b1;
            ST_RESP: bus_respack = beat_we;
            ST_DONE: fill_done   = 1'b1;
            default: fill_ready  = 1'b0;
        endcase
    end

    // Request address/tag are captured once at accept and stay put for the whole fill
    always_comb begin
        addr_next = addr_reg;
        tag_next  = tag_reg;
        cnt_next  = cnt_reg;
        if (accept) begin
            addr_next = fill_addr & LINE_MASK;
            tag_next  = REQ_TAG;
            cnt_next  = '0;
        end
        if (beat_we) begin
            cnt_next = cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_reg <= '0;
            tag_reg  <= '0;
            cnt_reg  <= '0;
        end else begin
            addr_reg <= addr_next;
            tag_reg  <= tag_next;
            cnt_reg  <= cnt_next;
        end
    end

    assign bus_req    = addr_reg;
    assign bus_reqtag = tag_reg;

    // One register per beat slot; a slot keeps its old contents until the next fill reaches it
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_beat
            logic [BUS_DATA_WIDTH-1:0] data_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    data_reg <= '0;
                end else if (beat_we && (cnt_reg == CNT_W'(gi))) begin
                    data_reg <= bus_resp;
                end
            end
            assign fill_line[gi*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] = data_reg;
        end
    endgenerate

endmodule

// File: tb/tb_bus_line_fill.sv
// Directed bench for bus_line_fill: table-driven first fill, then hand-written gap, overlap, reset and tag sequences.
module tb_bus_line_fill;

    localparam int         W     = 64;
    localparam int         TW    = 13;
    localparam int         BEATS = 8;
    localparam logic [7:0] SRC_ID   = 8'd0;
    localparam logic [12:0] TAG     = 13'h1100 | 13'(SRC_ID);
    localparam logic [12:0] TAG_BAD = 13'h1100 | 13'(SRC_ID + 8'd1);

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 fill_req;
    logic [W-1:0]         fill_addr;
    logic                 fill_ready;
    logic                 fill_done;
    logic [BEATS*W-1:0]   fill_line;
    logic                 bus_reqcyc;
    logic [W-1:0]         bus_req;
    logic [TW-1:0]        bus_reqtag;
    logic                 bus_reqack;
    logic                 bus_respcyc;
    logic [W-1:0]         bus_resp;
    logic [TW-1:0]        bus_resptag;
    logic                 bus_respack;

    int checks = 0;
    int errors = 0;

    bus_line_fill #(
        .BUS_DATA_WIDTH(W),
        .BUS_TAG_WIDTH (TW),
        .BEATS         (BEATS),
        .SRC_ID        (int'(SRC_ID))
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .fill_req    (fill_req),
        .fill_addr   (fill_addr),
        .fill_ready  (fill_ready),
        .fill_done   (fill_done),
        .fill_line   (fill_line),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          fr;
        logic [W-1:0]  fa;
        logic          ack;
        logic          rc;
        logic [W-1:0]  rd;
        logic [TW-1:0] rt;
        logic          e_ready;
        logic          e_done;
        logic          e_reqcyc;
        logic [W-1:0]  e_req;
        logic [TW-1:0] e_tag;
        logic          e_respack;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic fr, input logic [W-1:0] fa, input logic ack,
                          input logic rc, input logic [W-1:0] rd, input logic [TW-1:0] rt);
        fill_req    = fr;
        fill_addr   = fa;
        bus_reqack  = ack;
        bus_respcyc = rc;
        bus_resp    = rd;
        bus_resptag = rt;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait fill with checks on every cycle; returns on the cycle after fill_done.
    task automatic do_fill(input string name, input logic [W-1:0] addr, input logic [W-1:0] base);
        logic [511:0] el;
        el = '0;
        set_in(1'b1, addr, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk({name, "_ready"}, fill_ready, 1'b1);
        next_cycle();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk({name, "_reqcyc"}, bus_reqcyc, 1'b1);
        chk({name, "_req"}, bus_req, addr & ~64'h3F);
        chk({name, "_reqtag"}, bus_reqtag, TAG);
        next_cycle();
        for (int k = 0; k < BEATS; k++) begin
            set_in(1'b0, '0, 1'b0, 1'b1, base + W'(k), TAG);
            el[k*W +: W] = base + W'(k);
            @(negedge clk);
            chk($sformatf("%s_respack%0d", name, k), bus_respack, 1'b1);
            chk($sformatf("%s_nodone%0d", name, k), fill_done, 1'b0);
            next_cycle();
        end
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk({name, "_done"}, fill_done, 1'b1);
        chk({name, "_line"}, fill_line, el);
        next_cycle();
        $display("fill %s addr=%h base=%h complete", name, addr, base);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [511:0] exp_line;
        logic [511:0] exp_tag_line;
        int           exp_cnt;
        int           k;
        logic         acc;
        logic [TW-1:0] rt;

        // Vector table: the first fill, one row per clock cycle
        vecs[0]  = '{1'b1, 64'h1234, 1'b0, 1'b0, 64'h0,    TAG, 1'b1, 1'b0, 1'b0, 64'h0,    13'h0, 1'b0};
        vecs[1]  = '{1'b0, 64'hFFFF, 1'b0, 1'b1, 64'hDEAD, TAG, 1'b0, 1'b0, 1'b1, 64'h1200, TAG,   1'b0};
        vecs[2]  = '{1'b0, 64'hFFFF, 1'b1, 1'b0, 64'h0,    TAG, 1'b0, 1'b0, 1'b1, 64'h1200, TAG,   1'b0};
        for (int i = 0; i < BEATS; i++) begin
            vecs[3+i] = '{1'b0, 64'h0, (i == 0), 1'b1, 64'h11 * W'(i + 1), TAG,
                          1'b0, 1'b0, 1'b0, 64'h1200, TAG, 1'b1};
        end
        vecs[11] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h99, TAG, 1'b0, 1'b1, 1'b0, 64'h1200, TAG, 1'b0};
        vecs[12] = '{1'b0, 64'h0, 1'b0, 1'b1, 64'h77, TAG, 1'b1, 1'b0, 1'b0, 64'h1200, TAG, 1'b0};

        // Reset state
        reset = 1'b1;
        set_in(1'b0, '0, 1'b1, 1'b1, 64'h55, TAG);
        next_cycle();
        @(negedge clk);
        chk("rst_ready",   fill_ready,  1'b1);
        chk("rst_done",    fill_done,   1'b0);
        chk("rst_reqcyc",  bus_reqcyc,  1'b0);
        chk("rst_req",     bus_req,     64'h0);
        chk("rst_reqtag",  bus_reqtag,  13'h0);
        chk("rst_respack", bus_respack, 1'b0);
        chk("rst_line",    fill_line,   512'h0);
        next_cycle();
        reset = 1'b0;

        for (int i = 0; i < 13; i++) begin
            set_in(vecs[i].fr, vecs[i].fa, vecs[i].ack, vecs[i].rc, vecs[i].rd, vecs[i].rt);
            @(negedge clk);
            chk($sformatf("v%0d_ready",   i), fill_ready,  vecs[i].e_ready);
            chk($sformatf("v%0d_done",    i), fill_done,   vecs[i].e_done);
            chk($sformatf("v%0d_reqcyc",  i), bus_reqcyc,  vecs[i].e_reqcyc);
            chk($sformatf("v%0d_req",     i), bus_req,     vecs[i].e_req);
            chk($sformatf("v%0d_reqtag",  i), bus_reqtag,  vecs[i].e_tag);
            chk($sformatf("v%0d_respack", i), bus_respack, vecs[i].e_respack);
            $display("vec %0d: ready=%b done=%b reqcyc=%b req=%h respack=%b",
                     i, fill_ready, fill_done, bus_reqcyc, bus_req, bus_respack);
            next_cycle();
        end
        exp_line = '0;
        for (int i = 0; i < BEATS; i++) exp_line[i*W +: W] = 64'h11 * W'(i + 1);
        chk("v_line_lo", fill_line[63:0],    64'h11);
        chk("v_line_hi", fill_line[511:448], 64'h88);
        chk("v_line",    fill_line,          exp_line);

        // Beats separated by gaps, with a stray fill_req during RESP
        set_in(1'b1, 64'h2075, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("gap_ready", fill_ready, 1'b1);
        next_cycle();
        set_in(1'b0, 64'h0, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk("gap_req", bus_req, 64'h2040);
        next_cycle();
        for (int i = 0; i < 2*BEATS - 1; i++) begin
            set_in((i == 5), 64'h9999_0000, 1'b0, (i % 2 == 0), 64'h100 + W'(i / 2), TAG);
            if (i % 2 == 0) exp_line[(i/2)*W +: W] = 64'h100 + W'(i / 2);
            @(negedge clk);
            chk($sformatf("gap_respack%0d", i), bus_respack, (i % 2 == 0));
            chk($sformatf("gap_ready%0d", i), fill_ready, 1'b0);
            chk($sformatf("gap_done%0d", i), fill_done, 1'b0);
            if (i == 1) begin
                chk("gap_overwrite0", fill_line[63:0],   64'h100);
                chk("gap_hold1",      fill_line[127:64], 64'h22);
            end
            next_cycle();
        end
        set_in(1'b1, 64'hAAAA_0000, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("gap_done", fill_done, 1'b1);
        chk("gap_done_ready", fill_ready, 1'b0);
        chk("gap_line", fill_line, exp_line);
        $display("fill gap addr=2040 complete");
        next_cycle();

        // Second fill accepted only once ready is back, with the address seen then
        set_in(1'b1, 64'h4567, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("ovl_ready", fill_ready, 1'b1);
        chk("ovl_req_held", bus_req, 64'h2040);
        next_cycle();
        set_in(1'b0, 64'h0, 1'b1, 1'b0, '0, '0);
        @(negedge clk);
        chk("ovl_reqcyc", bus_reqcyc, 1'b1);
        chk("ovl_req", bus_req, 64'h4540);
        next_cycle();

        // Reset after the third beat aborts the fill
        for (int i = 0; i < 3; i++) begin
            set_in(1'b0, '0, 1'b0, 1'b1, 64'h500 + W'(i), TAG);
            @(negedge clk);
            chk($sformatf("abort_respack%0d", i), bus_respack, 1'b1);
            next_cycle();
        end
        reset = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        next_cycle();
        reset = 1'b0;
        set_in(1'b0, '0, 1'b1, 1'b1, 64'h5FF, TAG);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("abort_ready%0d", i),   fill_ready,  1'b1);
            chk($sformatf("abort_done%0d", i),    fill_done,   1'b0);
            chk($sformatf("abort_reqcyc%0d", i),  bus_reqcyc,  1'b0);
            chk($sformatf("abort_req%0d", i),     bus_req,     64'h0);
            chk($sformatf("abort_reqtag%0d", i),  bus_reqtag,  13'h0);
            chk($sformatf("abort_respack%0d", i), bus_respack, 1'b0);
            chk($sformatf("abort_line%0d", i),    fill_line,   512'h0);
            next_cycle();
        end
        $display("abort: reset mid-fill observed");
        do_fill("recover", 64'h7000_0013, 64'h700);

        // Foreign-tag beat: rejected with the tag check built in, accepted without it
        set_in(1'b1, 64'h8040, 1'b0, 1'b0, '0, '0);
        next_cycle();
        set_in(1'b0, '0, 1'b1, 1'b0, '0, '0);
        next_cycle();
        exp_tag_line = fill_line;
        exp_cnt = 0;
        k = 0;
        while (exp_cnt < BEATS && k < 20) begin
            rt = (k == 2) ? TAG_BAD : TAG;
`ifdef FILL_TAG_CHECK_EN
            acc = (rt == TAG);
`else
            acc = 1'b1;
`endif
            set_in(1'b0, '0, 1'b0, 1'b1, 64'h800 + W'(k), rt);
            @(negedge clk);
            chk($sformatf("tag_respack%0d", k), bus_respack, acc);
            chk($sformatf("tag_nodone%0d", k), fill_done, 1'b0);
            if (acc) begin
                exp_tag_line[exp_cnt*W +: W] = 64'h800 + W'(k);
                exp_cnt++;
            end
            next_cycle();
            k++;
        end
        chk("tag_beats_bound", (exp_cnt == BEATS), 1'b1);
        set_in(1'b0, '0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk("tag_done", fill_done, 1'b1);
        chk("tag_line", fill_line, exp_tag_line);
        $display("fill tag addr=8040 complete after %0d bus beats", k);
        next_cycle();
        @(negedge clk);
        chk("tag_idle_ready", fill_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
